// File: rtl/bus_access_ctrl.sv
// bus_access_ctrl: sequences one CPU memory access at a time onto the 8-bit
// data bus stage with a setup cycle, a one-cycle strobe, a programmable
// number of wait states, 6502 RDY stalling and an optional WAIT timeout.
//
//   state  | meaning
//   -------+---------------------------------------------------------------
//   IDLE   | waiting for req; address, data and direction latched on accept
//   SETUP  | bus_addr/bus_wdata stable, no strobe
//   STROBE | bus_read or bus_write high for this single cycle
//   WAIT   | wait states count down; leave when wcnt==0 and rdy, or timeout
//   DONE   | ack (and err on timeout) high for this single cycle
module bus_access_ctrl #(
   parameter int ADDR_W      = 16,
   parameter int DATA_W      = 8,
   parameter int WAIT_STATES = 0,
   parameter int TIMEOUT     = 255
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              req,
   input  logic              rnw,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   input  logic              rdy,
   input  logic [DATA_W-1:0] bus_data,
   output logic [ADDR_W-1:0] bus_addr,
   output logic [DATA_W-1:0] bus_wdata,
   output logic              bus_read,
   output logic              bus_write,
   output logic [DATA_W-1:0] rdata,
   output logic              ack,
   output logic              err,
   output logic              busy
);

   // tcnt only has to reach TIMEOUT-1; it saturates instead of wrapping so a
   // disabled timeout (TIMEOUT=0) cannot alias back to a terminal value.
   localparam int TCNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [3:0]        WCNT_INIT = 4'(WAIT_STATES);
   localparam logic [TCNT_W-1:0] TCNT_MAX  = {TCNT_W{1'b1}};
   localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SETUP,
      S_STROBE,
      S_WAIT,
      S_DONE
   } state_t;

   state_t            state;
   logic              rnw_q;
   logic [3:0]        wcnt;
   logic [TCNT_W-1:0] tcnt;

   // Access sequencer; strobes, ack, err and busy are all state-decoded flops.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= S_IDLE;
         rnw_q     <= 1'b0;
         wcnt      <= '0;
         tcnt      <= '0;
         bus_addr  <= '0;
         bus_wdata <= '0;
         bus_read  <= 1'b0;
         bus_write <= 1'b0;
         rdata     <= '0;
         ack       <= 1'b0;
         err       <= 1'b0;
         busy      <= 1'b0;
      end else begin
         bus_read  <= 1'b0;
         bus_write <= 1'b0;
         ack       <= 1'b0;
         err       <= 1'b0;
         case (state)
            S_IDLE: begin
               if (req) begin
                  bus_addr  <= addr;
                  bus_wdata <= wdata;
                  rnw_q     <= rnw;
                  busy      <= 1'b1;
                  state     <= S_SETUP;
               end
            end
            S_SETUP: begin
               bus_read  <= rnw_q;
               bus_write <= ~rnw_q;
               state     <= S_STROBE;
            end
            S_STROBE: begin
               wcnt  <= WCNT_INIT;
               tcnt  <= '0;
               state <= S_WAIT;
            end
            S_WAIT: begin
               if (wcnt != 4'd0) wcnt <= wcnt - 4'd1;
               if (tcnt != TCNT_MAX) tcnt <= tcnt + TCNT_W'(1);
               // Completion is checked first so it wins over a coincident timeout.
               if (wcnt == 4'd0 && rdy) begin
                  if (rnw_q) rdata <= bus_data;
                  ack   <= 1'b1;
                  state <= S_DONE;
               end else if (TIMEOUT != 0 && tcnt == TCNT_LAST) begin
                  ack   <= 1'b1;
                  err   <= 1'b1;
                  state <= S_DONE;
               end
            end
            S_DONE: begin
               busy  <= 1'b0;
               state <= S_IDLE;
            end
            default: begin
               busy  <= 1'b0;
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bus_access_ctrl.sv
// Bench for bus_access_ctrl: two instances (no wait states with an 8-cycle
// timeout, and two wait states with the default timeout) checked every cycle
// against a timing model keyed on the cycle an access was accepted.
module tb_bus_access_ctrl;

   localparam int WS [2] = '{0, 2};
   localparam int TO [2] = '{8, 255};

   logic clk = 1'b0;
   logic reset_n = 1'b0;

   logic        r_req [2];
   logic        r_rnw [2];
   logic [15:0] r_addr [2];
   logic [7:0]  r_wdata [2];
   logic        r_rdy [2];
   logic [7:0]  r_bd [2];

   logic [15:0] o_addr [2];
   logic [7:0]  o_wdata [2];
   logic        o_read [2];
   logic        o_write [2];
   logic [7:0]  o_rdata [2];
   logic        o_ack [2];
   logic        o_err [2];
   logic        o_busy [2];

   always #5 clk = ~clk;

   bus_access_ctrl #(.ADDR_W(16), .DATA_W(8), .WAIT_STATES(0), .TIMEOUT(8)) u_dut0 (
      .clk(clk), .reset_n(reset_n), .req(r_req[0]), .rnw(r_rnw[0]), .addr(r_addr[0]),
      .wdata(r_wdata[0]), .rdy(r_rdy[0]), .bus_data(r_bd[0]), .bus_addr(o_addr[0]),
      .bus_wdata(o_wdata[0]), .bus_read(o_read[0]), .bus_write(o_write[0]),
      .rdata(o_rdata[0]), .ack(o_ack[0]), .err(o_err[0]), .busy(o_busy[0]));

   bus_access_ctrl #(.ADDR_W(16), .DATA_W(8), .WAIT_STATES(2), .TIMEOUT(255)) u_dut1 (
      .clk(clk), .reset_n(reset_n), .req(r_req[1]), .rnw(r_rnw[1]), .addr(r_addr[1]),
      .wdata(r_wdata[1]), .rdy(r_rdy[1]), .bus_data(r_bd[1]), .bus_addr(o_addr[1]),
      .bus_wdata(o_wdata[1]), .bus_read(o_read[1]), .bus_write(o_write[1]),
      .rdata(o_rdata[1]), .ack(o_ack[1]), .err(o_err[1]), .busy(o_busy[1]));

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   // model: an access accepted so that SETUP is cycle m_a has STROBE in m_a+1,
   // WAIT from m_a+2, DONE in m_d, and the block is back in IDLE from m_free.
   bit          m_act [2];
   int          m_a [2];
   int          m_d [2];
   int          m_free [2];
   bit          m_rnw [2];
   bit          m_terr [2];
   logic [15:0] e_addr [2];
   logic [7:0]  e_wdata [2];
   logic [7:0]  e_rdata [2];

   logic        s_req [2];
   logic        s_rnw [2];
   logic [15:0] s_addr [2];
   logic [7:0]  s_wdata [2];
   logic        s_rdy [2];
   logic [7:0]  s_bd [2];

   typedef struct {
      int          inst;
      bit          rnw;
      logic [15:0] addr;
      logic [7:0]  wdata;
      logic [7:0]  bdata;
      int          stall;
      bit          pre;
      int          exp_lat;
      logic [7:0]  exp_rdata;
      bit          exp_err;
   } vec_t;

   vec_t vecs [8];

   task automatic chk(input string name, input int i, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         if (errors <= 40)
            $display("FAIL %s[%0d] cycle %0d got %0h expected %0h", name, i, cyc, act, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         m_act[i] = 1'b0; m_d[i] = -1; m_a[i] = -10; m_free[i] = cyc;
         m_rnw[i] = 1'b0; m_terr[i] = 1'b0;
         e_addr[i] = '0; e_wdata[i] = '0; e_rdata[i] = '0;
      end
   endtask

   task automatic model_step(input int i, input int c);
      if (!m_act[i] && c >= m_free[i]) begin
         if (s_req[i]) begin
            m_act[i] = 1'b1; m_a[i] = c + 1; m_rnw[i] = s_rnw[i];
            e_addr[i] = s_addr[i]; e_wdata[i] = s_wdata[i];
         end
      end else if (m_act[i] && c >= m_a[i] + 2) begin
         if (c >= m_a[i] + 2 + WS[i] && s_rdy[i]) begin
            m_act[i] = 1'b0; m_d[i] = c + 1; m_free[i] = c + 2; m_terr[i] = 1'b0;
            if (m_rnw[i]) e_rdata[i] = s_bd[i];
         end else if (TO[i] != 0 && c - (m_a[i] + 2) == TO[i] - 1) begin
            m_act[i] = 1'b0; m_d[i] = c + 1; m_free[i] = c + 2; m_terr[i] = 1'b1;
         end
      end
   endtask

   task automatic compare_all();
      for (int i = 0; i < 2; i++) begin
         logic e_ack;
         e_ack = (m_d[i] == cyc);
         chk("ack", i, o_ack[i], e_ack);
         chk("err", i, o_err[i], e_ack && m_terr[i]);
         chk("busy", i, o_busy[i], m_act[i] || e_ack);
         chk("bus_read", i, o_read[i], m_act[i] && cyc == m_a[i] + 1 && m_rnw[i]);
         chk("bus_write", i, o_write[i], m_act[i] && cyc == m_a[i] + 1 && !m_rnw[i]);
         chk("bus_addr", i, o_addr[i], e_addr[i]);
         chk("bus_wdata", i, o_wdata[i], e_wdata[i]);
         chk("rdata", i, o_rdata[i], e_rdata[i]);
         chk("strobe_excl", i, o_read[i] & o_write[i], 0);
      end
   endtask

   task automatic tick();
      for (int i = 0; i < 2; i++) begin
         s_req[i] = r_req[i]; s_rnw[i] = r_rnw[i]; s_addr[i] = r_addr[i];
         s_wdata[i] = r_wdata[i]; s_rdy[i] = r_rdy[i]; s_bd[i] = r_bd[i];
      end
      @(posedge clk);
      cyc++;
      if (!reset_n) model_reset();
      else for (int i = 0; i < 2; i++) model_step(i, cyc - 1);
      #1;
      compare_all();
   endtask

   function automatic logic rdy_fn(input vec_t v, input int rel);
      if (v.pre && rel >= 0 && rel < 2) return 1'b0;
      if (rel >= 2 && rel < 2 + v.stall) return 1'b0;
      return 1'b1;
   endfunction

   task automatic run_txn(input vec_t v);
      int i;
      int lat;
      i = v.inst;
      lat = -1;
      r_rnw[i] = v.rnw; r_addr[i] = v.addr; r_wdata[i] = v.wdata; r_bd[i] = v.bdata;
      for (int k = 0; k < 60; k++) begin
         r_req[i] = 1'b1;
         r_rdy[i] = rdy_fn(v, k - 1);
         tick();
         if (o_ack[i]) begin
            lat = k;
            break;
         end
      end
      chk("txn_latency", i, lat, v.exp_lat);
      chk("txn_rdata", i, o_rdata[i], v.exp_rdata);
      chk("txn_err", i, o_err[i], v.exp_err);
      r_req[i] = 1'b0;
      r_rdy[i] = 1'b1;
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int first_s, second_s, n_s;

      for (int i = 0; i < 2; i++) begin
         r_req[i] = 1'b0; r_rnw[i] = 1'b0; r_addr[i] = '0; r_wdata[i] = '0;
         r_rdy[i] = 1'b1; r_bd[i] = '0;
      end
      model_reset();

      //     inst rnw  addr      wdata  bdata  stall pre lat rdata  err
      vecs[0] = '{0, 1'b1, 16'h1234, 8'h00, 8'hA5, 0,  1'b0, 3,  8'hA5, 1'b0};
      vecs[1] = '{1, 1'b0, 16'hFFFE, 8'h3C, 8'hEE, 0,  1'b0, 5,  8'h00, 1'b0};
      vecs[2] = '{0, 1'b1, 16'h0042, 8'h00, 8'h5A, 4,  1'b0, 7,  8'h5A, 1'b0};
      vecs[3] = '{0, 1'b1, 16'h0777, 8'h00, 8'h99, 99, 1'b0, 10, 8'h5A, 1'b1};
      vecs[4] = '{1, 1'b1, 16'h8000, 8'h00, 8'hC3, 0,  1'b0, 5,  8'hC3, 1'b0};
      vecs[5] = '{1, 1'b1, 16'h1001, 8'h00, 8'h11, 3,  1'b0, 6,  8'h11, 1'b0};
      vecs[6] = '{0, 1'b0, 16'h2002, 8'h0F, 8'h66, 7,  1'b0, 10, 8'h5A, 1'b0};
      vecs[7] = '{0, 1'b1, 16'h3003, 8'h00, 8'h77, 0,  1'b1, 3,  8'h77, 1'b0};

      #1;
      compare_all();
      tick();
      tick();
      #2 reset_n = 1'b1;

      foreach (vecs[n]) run_txn(vecs[n]);

      // reset while the read strobe is high must drop it without a clock edge
      r_req[0] = 1'b1; r_rnw[0] = 1'b1; r_addr[0] = 16'hBEEF; r_bd[0] = 8'h42;
      tick();
      tick();
      chk("strobe_before_reset", 0, o_read[0], 1);
      #2 reset_n = 1'b0;
      model_reset();
      #1;
      chk("reset_read_async", 0, o_read[0], 0);
      chk("reset_ack_async", 0, o_ack[0], 0);
      chk("reset_busy_async", 0, o_busy[0], 0);
      chk("reset_addr_async", 0, o_addr[0], 0);
      r_req[0] = 1'b0;
      tick();
      #2 reset_n = 1'b1;
      tick();

      // held req on the wait-state instance: accesses every 5+2 cycles
      first_s = -1; second_s = -1; n_s = 0;
      r_req[1] = 1'b1; r_rnw[1] = 1'b1; r_rdy[1] = 1'b1; r_bd[1] = 8'hD2;
      for (int k = 0; k < 16; k++) begin
         r_addr[1] = 16'(k);
         tick();
         if (o_read[1]) begin
            if (n_s == 0) first_s = cyc;
            else if (n_s == 1) second_s = cyc;
            n_s++;
         end
      end
      r_req[1] = 1'b0;
      chk("b2b_first_strobe_seen", 1, first_s >= 0, 1);
      chk("b2b_period", 1, second_s - first_s, 7);
      for (int k = 0; k < 10; k++) tick();

      // random traffic on both instances against the model
      for (int k = 0; k < 600; k++) begin
         for (int i = 0; i < 2; i++) begin
            r_req[i] = ($urandom_range(0, 3) != 0);
            r_rnw[i] = 1'($urandom);
            r_addr[i] = 16'($urandom);
            r_wdata[i] = 8'($urandom);
            r_bd[i] = 8'($urandom);
            r_rdy[i] = ($urandom_range(0, 9) > 3);
         end
         tick();
      end
      for (int i = 0; i < 2; i++) begin
         r_req[i] = 1'b0;
         r_rdy[i] = 1'b1;
      end
      for (int k = 0; k < 12; k++) tick();
      chk("drain_idle", 0, o_busy[0], 0);
      chk("drain_idle", 1, o_busy[1], 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
